// File: rtl/qpsk_shaping_filter.sv
// QPSK pulse-shaping interpolator.
// Each accepted bit pair becomes a pair of +/-1 symbols. The symbols are
// upsampled by OSR through an OSR*NSYM-tap polyphase FIR whose
// coefficients can be written at run time. When no symbol is offered at a
// symbol boundary, a zero symbol is stuffed in its place. After NSYM
// stuffed zeros in a row the delay line is empty, so the block drops back
// to IDLE.

// One rail (I or Q): add, subtract or skip each tap, then clamp the sum
// to the OUT_W signed range.
module qpsk_rail_mac #(
  parameter int NSYM   = 4,
  parameter int COEF_W = 14,
  parameter int OUT_W  = 16
) (
  input  logic [NSYM-1:0]             nz,
  input  logic [NSYM-1:0]             neg,
  input  logic [NSYM-1:0][COEF_W-1:0] taps,
  output logic [OUT_W-1:0]            sample
);
  // One guard bit above COEF_W+clog2(NSYM) keeps the full-scale sum exact.
  localparam int SW = COEF_W + $clog2(NSYM) + 1;
  localparam int XW = (SW > OUT_W) ? SW : OUT_W;
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [XW-1:0] acc;

  // Symbols are only +1, -1 or 0, so no multipliers are needed.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NSYM; k++) begin
      if (nz[k]) begin
        if (neg[k]) acc = acc - XW'($signed(taps[k]));
        else        acc = acc + XW'($signed(taps[k]));
      end
    end
  end

  // Clamp to the output range. When OUT_W is wide enough, this is just a sign extension.
  always_comb begin
    if (acc > MAXV)      sample = MAXV[OUT_W-1:0];
    else if (acc < MINV) sample = MINV[OUT_W-1:0];
    else                 sample = acc[OUT_W-1:0];
  end
endmodule

module qpsk_shaping_filter #(
  parameter int OSR    = 4,
  parameter int NSYM   = 4,
  parameter int COEF_W = 14,
  parameter int OUT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gate,
  input  logic                          bit1,
  input  logic                          bit2,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic                          coef_we,
  input  logic [$clog2(OSR*NSYM)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]             coef_data,
  output logic [OUT_W-1:0]              real_out,
  output logic [OUT_W-1:0]              imag_out,
  output logic                          out_valid,
  output logic                          underrun,
  output logic                          busy
);
  localparam int NTAPS = OSR * NSYM;
  localparam int AW    = $clog2(NTAPS);
  localparam int PW    = $clog2(OSR);
  localparam int ZW    = $clog2(NSYM + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state, state_n;
  logic [PW-1:0]                 phase, phase_n;
  logic [ZW-1:0]                 zero_cnt, zero_cnt_n;
  logic [NTAPS-1:0][COEF_W-1:0]  coef;
  // Per-rail delay line: rail 0 = I, rail 1 = Q. Each entry is {nz, neg}.
  // An entry with nz = 0 is a stuffed zero.
  logic [1:0][NSYM-1:0]          d_nz, d_neg;
  logic [NSYM-1:0][COEF_W-1:0]   taps;
  logic [1:0][OUT_W-1:0]         sample;
  logic [1:0]                    sym_bits;
  logic                          last_phase, accept, shift, stuff;

  assign sym_bits   = {bit2, bit1};
  assign last_phase = (phase == PW'(OSR - 1));
  assign sym_ready  = gate && (state == IDLE || last_phase);
  assign accept     = sym_ready && sym_valid;
  assign busy       = (state == RUN);

  // Polyphase tap select: delay entry k at phase p uses coef[k*OSR + p].
  for (genvar k = 0; k < NSYM; k++) begin : g_tap
    assign taps[k] = coef[AW'(k * OSR) + AW'(phase)];
  end

  // Both rails share the same tap set.
  for (genvar r = 0; r < 2; r++) begin : g_rail
    qpsk_rail_mac #(.NSYM(NSYM), .COEF_W(COEF_W), .OUT_W(OUT_W)) u_mac (
      .nz    (d_nz[r]),
      .neg   (d_neg[r]),
      .taps  (taps),
      .sample(sample[r])
    );
  end

  // Next-state logic: symbol boundaries, zero stuffing and the drop back to IDLE.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    zero_cnt_n = zero_cnt;
    shift      = 1'b0;
    stuff      = 1'b0;
    if (gate) begin
      case (state)
        IDLE: if (accept) begin
          state_n    = RUN;
          phase_n    = '0;
          zero_cnt_n = '0;
        end
        RUN: if (last_phase) begin
          shift   = 1'b1;
          phase_n = '0;
          if (accept) zero_cnt_n = '0;
          else begin
            stuff      = 1'b1;
            zero_cnt_n = zero_cnt + ZW'(1);
            if (zero_cnt == ZW'(NSYM - 1)) begin
              state_n = IDLE;
              phase_n = PW'(OSR - 1);
            end
          end
        end else begin
          phase_n = phase + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // State, phase and zero-run counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= PW'(OSR - 1);
      zero_cnt <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      zero_cnt <= zero_cnt_n;
    end
  end

  // Coefficient RAM. Writes ignore gate and state. Addresses at or above NTAPS match no tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef            <= '0;
      coef[NTAPS / 2] <= COEF_W'(1) << (COEF_W - 2);
    end else begin
      for (int i = 0; i < NTAPS; i++)
        if (coef_we && coef_addr == AW'(i)) coef[i] <= coef_data;
    end
  end

  // Delay line and registered outputs. Samples use pre-edge coefficients and delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_nz      <= '0;
      d_neg     <= '0;
      real_out  <= '0;
      imag_out  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (!gate) begin
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (state == IDLE) begin
      real_out  <= '0;
      imag_out  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      if (accept) begin
        for (int r = 0; r < 2; r++) begin
          d_nz[r][0]  <= 1'b1;
          d_neg[r][0] <= sym_bits[r];
        end
      end
    end else begin
      real_out  <= sample[0];
      imag_out  <= sample[1];
      out_valid <= 1'b1;
      underrun  <= stuff;
      if (shift) begin
        for (int r = 0; r < 2; r++) begin
          for (int k = 1; k < NSYM; k++) begin
            d_nz[r][k]  <= d_nz[r][k-1];
            d_neg[r][k] <= d_neg[r][k-1];
          end
          d_nz[r][0]  <= accept;
          d_neg[r][0] <= accept && sym_bits[r];
        end
      end
    end
  end
endmodule

// File: tb/tb_qpsk_shaping_filter.sv
// Bench for qpsk_shaping_filter: a 16-bit and a 14-bit output instance share all inputs.
module tb_qpsk_shaping_filter;
  localparam int OSR = 4, NSYM = 4, COEF_W = 14, NTAPS = 16;

  logic clk = 1'b0;
  logic rst, gate, bit1, bit2, sym_valid, coef_we;
  logic [3:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic rdy_a, rdy_b, ov_a, ov_b, un_a, un_b, busy_a, busy_b;
  logic [15:0] re_a, im_a;
  logic [13:0] re_b, im_b;

  int vectors = 0, miscompares = 0;

  // Reference model state, in plain integers.
  int mcoef[NTAPS];
  int md_i[NSYM], md_q[NSYM];
  bit mrun;
  int mph, mzc, mre, mim;
  bit mov, mun;

  bit pat_i[64], pat_q[64];
  int q_re[$], q_im[$], q_re14[$], ref_re[$], ref_im[$];
  int n_un;

  qpsk_shaping_filter dut_a (
    .clk(clk), .rst(rst), .gate(gate), .bit1(bit1), .bit2(bit2),
    .sym_valid(sym_valid), .sym_ready(rdy_a), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .real_out(re_a),
    .imag_out(im_a), .out_valid(ov_a), .underrun(un_a), .busy(busy_a));

  qpsk_shaping_filter #(.OUT_W(14)) dut_b (
    .clk(clk), .rst(rst), .gate(gate), .bit1(bit1), .bit2(bit2),
    .sym_valid(sym_valid), .sym_ready(rdy_b), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .real_out(re_b),
    .imag_out(im_b), .out_valid(ov_b), .underrun(un_b), .busy(busy_b));

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 999999;
  endfunction

  function automatic bit mready();
    return gate && (!mrun || mph == OSR - 1);
  endfunction

  task automatic model_reset();
    foreach (mcoef[i]) mcoef[i] = 0;
    mcoef[NTAPS/2] = 1 << (COEF_W - 2);
    foreach (md_i[k]) begin md_i[k] = 0; md_q[k] = 0; end
    mrun = 0; mph = OSR - 1; mzc = 0; mre = 0; mim = 0; mov = 0; mun = 0;
  endtask

  // One clock edge of the specified behaviour. The sample uses pre-edge coefficients.
  task automatic model_edge();
    int s_re, s_im;
    bit acc;
    if (rst) begin model_reset(); return; end
    s_re = 0; s_im = 0;
    for (int k = 0; k < NSYM; k++) begin
      s_re += md_i[k] * mcoef[k*OSR + mph];
      s_im += md_q[k] * mcoef[k*OSR + mph];
    end
    if (gate) begin
      acc = sym_valid && mready();
      mun = 0;
      if (!mrun) begin
        mov = 0; mre = 0; mim = 0;
        if (acc) begin
          md_i[0] = bit1 ? -1 : 1; md_q[0] = bit2 ? -1 : 1;
          mph = 0; mzc = 0; mrun = 1;
        end
      end else begin
        mre = s_re; mim = s_im; mov = 1;
        if (mph == OSR - 1) begin
          for (int k = NSYM - 1; k > 0; k--) begin md_i[k] = md_i[k-1]; md_q[k] = md_q[k-1]; end
          md_i[0] = acc ? (bit1 ? -1 : 1) : 0;
          md_q[0] = acc ? (bit2 ? -1 : 1) : 0;
          mph = 0;
          if (acc) mzc = 0;
          else begin
            mzc++; mun = 1;
            if (mzc == NSYM) begin mrun = 0; mph = OSR - 1; end
          end
        end else mph++;
      end
    end else begin
      mov = 0; mun = 0;
    end
    if (coef_we) mcoef[coef_addr] = $signed(coef_data);
  endtask

  task automatic check_outputs();
    chk("real16", $signed(re_a), sat(mre, 16));
    chk("imag16", $signed(im_a), sat(mim, 16));
    chk("real14", $signed(re_b), sat(mre, 14));
    chk("imag14", $signed(im_b), sat(mim, 14));
    chk("out_valid", ov_a, mov);
    chk("out_valid14", ov_b, mov);
    chk("underrun", un_a, mun);
    chk("busy", busy_a, mrun);
  endtask

  // Inputs are set by the caller at edge+1. sym_ready is checked before the edge, outputs after it.
  task automatic tick();
    #1;
    chk("sym_ready", rdy_a, mready());
    chk("sym_ready14", rdy_b, mready());
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Offer n symbols from pat_i/pat_q, then wait for the block to return to IDLE.
  task automatic stream(input int n, input bit toggle);
    int idx, guard;
    bit acc;
    idx = 0; guard = 0; n_un = 0;
    q_re.delete(); q_im.delete(); q_re14.delete();
    gate = 1; coef_we = 0;
    while ((idx < n || mrun) && guard < 400) begin
      sym_valid = (idx < n);
      bit1 = pat_i[(idx < n) ? idx : 0];
      bit2 = pat_q[(idx < n) ? idx : 0];
      acc = sym_valid && mready();
      tick();
      if (ov_a) begin
        q_re.push_back(int'($signed(re_a)));
        q_im.push_back(int'($signed(im_a)));
        q_re14.push_back(int'($signed(re_b)));
      end
      if (un_a) n_un++;
      if (acc) idx++;
      if (toggle) gate = ~gate;
      guard++;
    end
    sym_valid = 0; gate = 1;
    chk("stream_idle", busy_a, 0);
  endtask

  initial begin
    int s9_re, s9_im, nz_other, guard;
    logic [COEF_W-1:0] cval;

    // Reset for 10 time units.
    rst = 1; gate = 1; bit1 = 0; bit2 = 0; sym_valid = 0;
    coef_we = 0; coef_addr = '0; coef_data = '0;
    model_reset();
    #3;
    check_outputs();
    chk("reset_ready", rdy_a, 1);
    #7 rst = 0;
    for (int i = 0; i < 50; i++) tick();

    // Single symbol (+1, -1) with the default coefficients.
    pat_i[0] = 0; pat_q[0] = 1;
    stream(1, 0);
    chk("single_count", q_re.size(), 16);
    chk("single_underruns", n_un, 4);
    s9_re = 12345; s9_im = 12345; nz_other = 0;
    for (int i = 0; i < q_re.size(); i++) begin
      if (i == 8) begin s9_re = q_re[i]; s9_im = q_im[i]; end
      else if (q_re[i] != 0 || q_im[i] != 0) nz_other++;
    end
    chk("single_s9_re", s9_re, 4096);
    chk("single_s9_im", s9_im, -4096);
    chk("single_other_zero", nz_other, 0);

    // Continuous stream with I alternating and Q = 0.
    for (int i = 0; i < 12; i++) begin pat_i[i] = i[0]; pat_q[i] = 0; end
    stream(12, 0);
    chk("cont_count", q_re.size(), 60);
    chk("cont_underruns", n_un, 4);
    chk("cont_s8_re", qat(q_re, 8), 4096);
    chk("cont_s12_re", qat(q_re, 12), -4096);
    chk("cont_s9_re", qat(q_re, 9), 0);
    chk("cont_s8_im", qat(q_im, 8), 4096);
    ref_re = q_re; ref_im = q_im;

    // The same stream with gate toggling every cycle must give the same samples.
    stream(12, 1);
    chk("gate_count", q_re.size(), ref_re.size());
    for (int i = 0; i < ref_re.size(); i++) begin
      chk("gate_seq_re", qat(q_re, i), ref_re[i]);
      chk("gate_seq_im", qat(q_im, i), ref_im[i]);
    end

    // Random traffic: gate, valid, bits and coefficient writes all random.
    for (int i = 0; i < 300; i++) begin
      gate = ($urandom_range(0, 3) != 0);
      sym_valid = ($urandom_range(0, 4) != 0);
      bit1 = 1'($urandom_range(0, 1));
      bit2 = 1'($urandom_range(0, 1));
      coef_we = ($urandom_range(0, 9) == 0);
      coef_addr = 4'($urandom);
      coef_data = COEF_W'($urandom);
      tick();
    end
    coef_we = 0; sym_valid = 0; gate = 1;
    guard = 0;
    while (mrun && guard < 40) begin tick(); guard++; end
    chk("random_drain_idle", busy_a, 0);

    // Saturation: every tap 8191. Half the writes are made with gate low.
    for (int a = 0; a < NTAPS; a++) begin
      gate = a[0]; coef_we = 1; coef_addr = 4'(a); coef_data = 14'd8191;
      tick();
    end
    coef_we = 0; gate = 1;
    for (int i = 0; i < 8; i++) begin pat_i[i] = 0; pat_q[i] = 0; end
    stream(8, 0);
    chk("sat_pos14", qat(q_re14, 12), 8191);
    chk("sat_pos16", qat(q_re, 12), 32764);
    for (int i = 0; i < 8; i++) pat_i[i] = 1;
    stream(8, 0);
    chk("sat_neg14", qat(q_re14, 12), -8192);
    chk("sat_neg16", qat(q_re, 12), -32764);

    // Write coef[0] = -100 mid-stream, then reset while in RUN.
    gate = 1; sym_valid = 1;
    for (int i = 0; i < 10; i++) begin
      bit1 = 1'($urandom_range(0, 1)); bit2 = 1'($urandom_range(0, 1));
      tick();
    end
    cval = COEF_W'(-100);
    coef_we = 1; coef_addr = 4'd0; coef_data = cval;
    tick();
    coef_we = 0;
    for (int i = 0; i < 8; i++) begin
      bit1 = 1'($urandom_range(0, 1)); bit2 = 1'($urandom_range(0, 1));
      tick();
    end
    chk("pre_rst_busy", busy_a, 1);
    #2 rst = 1;
    #1;
    chk("rst_real", $signed(re_a), 0);
    chk("rst_imag", $signed(im_a), 0);
    chk("rst_valid", ov_a, 0);
    chk("rst_busy", busy_a, 0);
    model_reset();
    sym_valid = 0;
    tick();
    rst = 0;
    pat_i[0] = 1; pat_q[0] = 0;
    stream(1, 0);
    chk("post_rst_s0_re", qat(q_re, 0), 0);
    chk("post_rst_s9_re", qat(q_re, 8), -4096);
    chk("post_rst_s9_im", qat(q_im, 8), 4096);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
